// File: rtl/store_commit_queue_if.sv
// store_commit_queue_if: dispatch, update, commit/flush and memory-drain signals of the store queue
interface store_commit_queue_if #(
    parameter int TAG_W = 5
);
    logic             rdy;
    logic             alloc_vld;
    logic [TAG_W-1:0] alloc_tag;
    logic [1:0]       alloc_size;
    logic             full;
    logic             empty;
    logic             upd_vld;
    logic [TAG_W-1:0] upd_tag;
    logic [31:0]      upd_addr;
    logic [31:0]      upd_data;
    logic             str_done;
    logic [TAG_W-1:0] str_done_tag;
    logic             commit;
    logic             flush;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;
    logic [1:0]       mem_size;
    logic             mem_ack;
    logic             err;
    modport master (
        output rdy, alloc_vld, alloc_tag, alloc_size, upd_vld, upd_tag, upd_addr, upd_data,
               commit, flush, mem_ack,
        input  full, empty, str_done, str_done_tag, mem_req, mem_addr, mem_data, mem_size, err
    );
    modport slave (
        input  rdy, alloc_vld, alloc_tag, alloc_size, upd_vld, upd_tag, upd_addr, upd_data,
               commit, flush, mem_ack,
        output full, empty, str_done, str_done_tag, mem_req, mem_addr, mem_data, mem_size, err
    );
endinterface

// File: rtl/store_commit_queue.sv
// store_commit_queue: circular store queue allocated in program order, filled by tag,
// committed in order by the reorder buffer and drained to memory over req/ack
module store_commit_queue #(
    parameter int SQ_SZ     = 16,
    parameter int SQ_SZ_LOG = 4,
    parameter int TAG_W     = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    store_commit_queue_if.slave bus
);
    typedef enum logic {IDLE, WAIT} drain_st_e;
    drain_st_e            st_q;
    logic [SQ_SZ-1:0]     vld_q, fil_q, cmt_q, vld_d, fil_d, cmt_d;
    logic [TAG_W-1:0]     tag_q  [SQ_SZ];
    logic [1:0]           size_q [SQ_SZ];
    logic [31:0]          addr_q [SQ_SZ];
    logic [31:0]          data_q [SQ_SZ];
    logic [SQ_SZ_LOG-1:0] head_q, cptr_q, tail_q, head_d, cptr_d, tail_d, hit_idx;
    logic [SQ_SZ_LOG:0]   count_d;
    logic                 hit, do_cmt, do_ret, do_alloc, do_upd, err_d;
    logic                 full_q, empty_q, err_q, str_done_q, mem_req_q;
    logic [TAG_W-1:0]     str_done_tag_q;
    logic [31:0]          mem_addr_q, mem_data_q;
    logic [1:0]           mem_size_q;
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < SQ_SZ; i++)
            if (vld_q[i] && !cmt_q[i] && tag_q[i] == bus.upd_tag) begin
                hit     = 1'b1;
                hit_idx = SQ_SZ_LOG'(i);
            end
        do_cmt   = bus.commit && vld_q[cptr_q] && !cmt_q[cptr_q] && fil_q[cptr_q];
        do_ret   = st_q == WAIT && bus.mem_ack;
        // a full queue still accepts an alloc when the head retires in the same cycle
        do_alloc = bus.alloc_vld && !bus.flush && (!full_q || do_ret);
        do_upd   = bus.upd_vld && hit && (!bus.flush || (do_cmt && hit_idx == cptr_q));
        err_d    = err_q || (bus.alloc_vld && !bus.flush && !do_alloc) || (bus.commit && !do_cmt);
        head_d   = head_q + SQ_SZ_LOG'(do_ret);
        cptr_d   = cptr_q + SQ_SZ_LOG'(do_cmt);
        tail_d   = bus.flush ? cptr_d : tail_q + SQ_SZ_LOG'(do_alloc);
        vld_d    = vld_q;
        fil_d    = fil_q;
        cmt_d    = cmt_q;
        if (do_ret) vld_d[head_q] = 1'b0;
        if (do_cmt) cmt_d[cptr_q] = 1'b1;
        if (do_upd) fil_d[hit_idx] = 1'b1;
        if (bus.flush) vld_d = vld_d & cmt_d;
        if (do_alloc) begin
            vld_d[tail_q] = 1'b1;
            fil_d[tail_q] = 1'b0;
            cmt_d[tail_q] = 1'b0;
        end
        count_d = '0;
        for (int i = 0; i < SQ_SZ; i++) count_d = count_d + (SQ_SZ_LOG+1)'(vld_d[i]);
    end
    always_ff @(posedge clk_i) begin
        if (bus.rdy) begin
            if (do_alloc) begin
                tag_q[tail_q]  <= bus.alloc_tag;
                size_q[tail_q] <= bus.alloc_size;
            end
            if (do_upd) begin
                addr_q[hit_idx] <= bus.upd_addr;
                data_q[hit_idx] <= bus.upd_data;
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q           <= IDLE;
            vld_q          <= '0;
            fil_q          <= '0;
            cmt_q          <= '0;
            head_q         <= '0;
            cptr_q         <= '0;
            tail_q         <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            err_q          <= 1'b0;
            str_done_q     <= 1'b0;
            str_done_tag_q <= '0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            mem_size_q     <= '0;
        end else if (bus.rdy) begin
            vld_q          <= vld_d;
            fil_q          <= fil_d;
            cmt_q          <= cmt_d;
            head_q         <= head_d;
            cptr_q         <= cptr_d;
            tail_q         <= tail_d;
            full_q         <= count_d == (SQ_SZ_LOG+1)'(SQ_SZ);
            empty_q        <= count_d == '0;
            err_q          <= err_d;
            str_done_q     <= do_upd;
            str_done_tag_q <= do_upd ? bus.upd_tag : '0;
            case (st_q)
                IDLE: if (vld_q[head_q] && cmt_q[head_q]) begin
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= addr_q[head_q];
                    mem_data_q <= data_q[head_q];
                    mem_size_q <= size_q[head_q];
                    st_q       <= WAIT;
                end
                WAIT: if (bus.mem_ack) begin
                    mem_req_q <= 1'b0;
                    st_q      <= IDLE;
                end
            endcase
        end
    end
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.err          = err_q;
    assign bus.str_done     = str_done_q;
    assign bus.str_done_tag = str_done_tag_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data     = mem_data_q;
    assign bus.mem_size     = mem_size_q;
endmodule

// File: doc/store_commit_queue.md
Name: store_commit_queue

Overview:
- Circular FIFO of in-flight stores. Stores are allocated at dispatch in program order and tagged with their reorder-buffer index.
- Address/data are filled by the address/data unit. Completion is signalled back to the reorder buffer.
- Each commit pulse from the reorder buffer marks the oldest uncommitted store committed. Committed stores drain to memory in order over a req/ack handshake.
- Sits between dispatch, the reorder buffer's commit/flush outputs and the memory controller.

Parameters:
SQ_SZ, 16, number of entries (power of two)
SQ_SZ_LOG, 4, log2(SQ_SZ)
TAG_W, 5, reorder-buffer tag width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  pause: when low, all state frozen
alloc_vld  in  1  allocate a store at tail
alloc_tag  in  TAG_W  reorder-buffer index of the store
alloc_size  in  2  0=byte, 1=half, 2=word
full  out  1  count==SQ_SZ
empty  out  1  count==0
upd_vld  in  1  address/data ready for a tagged store
upd_tag  in  TAG_W  tag to match
upd_addr  in  32  store address
upd_data  in  32  store data
str_done  out  1  one-cycle pulse to reorder buffer: store filled
str_done_tag  out  TAG_W  tag of filled store
commit  in  1  reorder buffer commits oldest uncommitted store
flush  in  1  mispredict reset: drop all uncommitted stores
mem_req  out  1  write request
mem_addr  out  32  write address
mem_data  out  32  write data, low bytes significant
mem_size  out  2  copy of entry size
mem_ack  in  1  write accepted; level, held until mem_req drops
err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst low, async): head, cptr and tail=0; count=0; all entries invalid; drain FSM=IDLE; every output 0 except empty=1.
- Sampling: everything below applies only on a clk rising edge with rdy high. With rdy low nothing changes; mem_req and its fields hold.
- Pointers: head (oldest), cptr (oldest uncommitted), tail (next free). SQ_SZ_LOG bits, natural wrap. count is SQ_SZ_LOG+1 bits. Invariant: head <= cptr <= tail in ring order.
- Per-entry state: valid, filled, committed, tag, size, addr, data.
- Alloc: if alloc_vld and !full, entry[tail] is written valid, !filled, !committed; tail+1. If alloc_vld while full, the alloc is ignored and err is set.
- Update: upd_vld matches upd_tag against valid, !committed entries.
  - On a hit: store addr/data, set filled; next cycle str_done=1 with str_done_tag=upd_tag.
  - On a miss: no state change, no pulse.
  - Tags are unique, so there is at most one hit.
- Commit: entry[cptr].committed=1; cptr+1.
  - Commit with cptr==tail, or with entry[cptr] not filled: ignored, err set.
- Flush: tail <= cptr, invalidating entries cptr..tail-1. Committed entries still drain.
  - Commit and flush in the same cycle: commit applies first, then tail <= cptr+1.
  - alloc_vld in a flush cycle is ignored.
  - upd_vld in a flush cycle is applied only if it hits an entry that survives the flush.
- Drain FSM:
  - IDLE: if count>0 and entry[head].committed, register addr/data/size onto mem_*, set mem_req=1, go to WAIT.
  - WAIT: mem_* are held stable. On mem_ack: mem_req=0, invalidate entry[head], head+1, count-1, go to IDLE.
  - Minimum spacing between requests is one IDLE cycle (at most one store per 2 cycles).
  - Flush never affects WAIT or any committed entry.
- Count: alloc and drain-retire in the same cycle leave count unchanged. full and empty are registered from the next count.
- Latency: upd to str_done is 1 cycle. Commit to mem_req for head is 2 cycles minimum (commit edge, then IDLE issue edge).

Test Plan:
- Alloc tags 3,4 (word); upd tag 4 (addr 0x100, data 0xAA) -> str_done next cycle, tag 4. Upd tag 3 (0x200, 0xBB) -> str_done tag 3. Two commits -> mem_req addr 0x200 data 0xBB, ack; then mem_req 0x100 0xAA, ack -> empty=1.
- Fill all 16 entries -> full=1. 17th alloc ignored, err=1. One drain-retire with a concurrent alloc -> count stays 16, full stays 1.
- Alloc tags 1,2,3; fill all three; commit once; flush -> tail=cptr=1. Entry tag1 still drains at its address. Later upd tag 2 -> no str_done. empty=1 after ack.
- Commit and flush in the same cycle with 2 uncommitted filled entries -> first is committed and drains, second is dropped, count=1.
- Hold mem_ack low for 5 cycles in WAIT, and rdy low for 3 cycles -> mem_req/addr/data stable throughout, head unchanged until an ack is sampled with rdy high.
- Assert rst low mid-WAIT -> mem_req=0, empty=1, err=0 immediately (async), with no clk edge needed.
